stream_framer: RTL
==================

# stream_framer

Parametrised multi-channel framer that sits between the audio AXI-stream source and `transform_top`. It collects interleaved samples into a circular buffer per channel and emits overlapping frames of `g_N` samples every `g_HOP` sample sets, channel by channel. Each frame ends with a last marker and carries a channel tag. This adds overlap, multi-channel support and frame delimiting, which the single-channel 512-point transform path does not provide.

## Interface
- `g_N`, 512: frame length in samples. Power of two, at least 4.
- `g_HOP`, 256: samples per channel between frame starts. Range 1..`g_N`.
- `g_CHANNELS`, 2: interleaved channel count. Range 1..8.
- `g_WIDTH`, 16: sample width in bits.
- `i_clk` in 1: single clock; all logic on the rising edge.
- `i_reset` in 1: synchronous, active-high reset.
- `o_axisInReady` out 1: framer accepts an input sample.
- `i_axisInData` in `g_WIDTH`: input sample. Channels are interleaved ch0, ch1, … ch(C-1), then ch0 again.
- `i_axisInValid` in 1: input sample valid.
- `i_axisOutReady` in 1: downstream accepts an output sample.
- `o_axisOutData` out `g_WIDTH`: frame sample, oldest first.
- `o_axisOutValid` out 1: output sample valid.
- `o_axisOutLast` out 1: marks the final sample of one channel's frame.
- `o_axisOutChannel` out `max(1,$clog2(g_CHANNELS))`: channel of the current frame.

## Operation
- Handshake: a transfer occurs when valid and ready are both high on a rising edge. Once `o_axisOutValid` is asserted, it and all output fields hold steady until the transfer completes.
- Storage: `g_CHANNELS`×`g_N` words. Address is channel×`g_N` plus a ring index.
- Write side:
  - Channel counter chIdx increments on each input transfer and wraps at C-1.
  - The ring index wrIdx increments (modulo `g_N`) when chIdx wraps.
  - Each wrap completes one "set".
- States:
  - FILL: the reset state. Counts sets up to `g_N`. When the `g_N`-th set completes, go to EMIT.
  - EMIT: `o_axisInReady`=0. For ch = 0..C-1, output `g_N` samples from ring index wrIdx (the oldest sample) through wrIdx-1, with wrap-around. `o_axisOutLast`=1 on the `g_N`-th beat of each channel. After the final beat of ch C-1 transfers, go to HOP with the hop counter cleared.
  - HOP: input is accepted and sets are counted. When the `g_HOP`-th set completes, go to EMIT.
- In HOP, the ring slots overwritten are exactly the oldest `g_HOP` samples per channel. Unread data is never overwritten.
- `g_HOP`=`g_N` gives disjoint frames.
- Partial sets (chIdx≠0) never trigger emission.
- Data passes through unmodified. There is no arithmetic on samples.

## Timing
- Reset values:
  - `o_axisInReady`=1, `o_axisOutValid`=0, `o_axisOutLast`=0, `o_axisOutChannel`=0, `o_axisOutData`=0.
  - State FILL; chIdx, wrIdx and set counters all 0.
- Memory read latency is 1 cycle. The output path uses a register plus one-entry skid (or equivalent prefetch).
- Trigger timing: if the trigger set completes on cycle t, then:
  - `o_axisInReady`=0 from t+1.
  - First `o_axisOutValid`=1 at t+2.
- Throughput: with `i_axisOutReady` held high, a frame group of C×`g_N` beats completes in C×`g_N` consecutive cycles with no bubbles. This includes the channel boundaries.
- Exit from EMIT: `o_axisInReady` returns to 1 on the cycle after the last output transfer. `o_axisOutValid` is 0 in that same cycle.
- Reset mid-operation takes priority over everything. The next cycle shows reset values, and `g_N` full sets must be refilled before output resumes.
- During EMIT, a presented input sample stays pending and is not consumed.

## Structure
- Package `stream_framer_pkg`:
  - state enum `t_framerState` {FILL, EMIT, HOP}.
  - width helper functions for counter and channel widths.
- Sub-module `framer_ram`: simple dual-port RAM with synchronous read, depth `g_CHANNELS`×`g_N`, width `g_WIDTH`.
- Top level contains the FSM, the counters and the output skid.

## Test plan
All scenarios use `g_N`=8, `g_HOP`=4, `g_CHANNELS`=2, `g_WIDTH`=16. Input sample n of channel c = c·0x1000+n.
- Reset, then 7 sets: no output. 8th set: ch0 0x0000..0x0007 with last on 0x0007, then ch1 0x1000..0x1007, 16 beats in 16 cycles, first valid at t+2.
- After the previous frame group, sets n=8..11: ch0 0x0004..0x000B and ch1 0x1004..0x100B. Confirms overlap and ring wrap.
- `i_axisOutReady` high one cycle in three: same data sequence, with outputs stable across every stalled cycle.
- Upstream holds valid with 0xBEEF during EMIT: `o_axisInReady`=0 for the whole group. 0xBEEF is consumed only after the last transfer, as ch0 of the next set.
- `i_reset` pulsed after 5 output beats: valid=0 and ready=1 the next cycle. 8 fresh sets are then needed before output, and the new frame holds only the post-reset data.
- `g_HOP`=8 variant: second frame ch0 is 0x0008..0x000F, disjoint from the first frame.

Source files
------------

// File: rtl/stream_framer_pkg.sv
// Shared types and width helpers for the multi-channel overlapping framer.
package stream_framer_pkg;

    typedef enum logic [1:0] {FILL, EMIT, HOP} t_framerState;

    function automatic int f_chanWidth(input int channels);
        return (channels <= 1) ? 1 : $clog2(channels);
    endfunction

    // Set counters must be able to hold the value g_N itself.
    function automatic int f_cntWidth(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/stream_framer_if.sv
// Input and output AXI-stream handshakes of the framer, bundled as one port.
interface stream_framer_if
    import stream_framer_pkg::*;
#(
    parameter int g_WIDTH    = 16,
    parameter int g_CHANNELS = 2
);
    localparam int LP_CH_W = f_chanWidth(g_CHANNELS);

    logic               o_axisInReady;
    logic [g_WIDTH-1:0] i_axisInData;
    logic               i_axisInValid;
    logic               i_axisOutReady;
    logic [g_WIDTH-1:0] o_axisOutData;
    logic               o_axisOutValid;
    logic               o_axisOutLast;
    logic [LP_CH_W-1:0] o_axisOutChannel;

    modport slave (
        output o_axisInReady,
        input  i_axisInData, i_axisInValid, i_axisOutReady,
        output o_axisOutData, o_axisOutValid, o_axisOutLast, o_axisOutChannel
    );

    modport master (
        input  o_axisInReady,
        output i_axisInData, i_axisInValid, i_axisOutReady,
        input  o_axisOutData, o_axisOutValid, o_axisOutLast, o_axisOutChannel
    );
endinterface

// File: rtl/stream_framer_ram.sv
// Simple dual-port sample store; the read register only updates on i_rdEn so it
// doubles as the held output stage while downstream stalls.
module framer_ram #(
    parameter int g_DEPTH  = 1024,
    parameter int g_WIDTH  = 16,
    parameter int g_ADDR_W = $clog2(g_DEPTH)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_wrEn,
    input  logic [g_ADDR_W-1:0] i_wrAddr,
    input  logic [g_WIDTH-1:0]  i_wrData,
    input  logic                i_rdEn,
    input  logic [g_ADDR_W-1:0] i_rdAddr,
    output logic [g_WIDTH-1:0]  o_rdData
);
    logic [g_WIDTH-1:0] r_mem [g_DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wrEn) r_mem[i_wrAddr] <= i_wrData;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)     o_rdData <= '0;
        else if (i_rdEn) o_rdData <= r_mem[i_rdAddr];
    end
endmodule

// File: rtl/stream_framer.sv
// Collects interleaved samples into per-channel rings and emits overlapping
// g_N-sample frames every g_HOP sets, channel by channel, with last and tag.
module stream_framer
    import stream_framer_pkg::*;
#(
    parameter int g_N        = 512,
    parameter int g_HOP      = 256,
    parameter int g_CHANNELS = 2,
    parameter int g_WIDTH    = 16
) (
    input logic           i_clk,
    input logic           i_reset,
    stream_framer_if.slave bus
);
    localparam int LP_IDX_W = $clog2(g_N);
    localparam int LP_CH_W  = f_chanWidth(g_CHANNELS);
    localparam int LP_CNT_W = f_cntWidth(g_N);
    localparam int LP_AW    = $clog2(g_CHANNELS * g_N);

    t_framerState          r_state, w_nextState;
    logic [LP_CH_W-1:0]    r_chIdx, r_rdCh, r_outCh;
    logic [LP_IDX_W-1:0]   r_wrIdx, r_rdIdx;
    logic [LP_CNT_W-1:0]   r_setCnt;
    logic                  r_rdDone, r_outValid, r_outLast;
    logic                  w_inReady, w_inFire, w_chWrap, w_setDone;
    logic                  w_pop, w_lastBeat, w_issue, w_rdIdxLast, w_rdChLast;
    logic [LP_IDX_W-1:0]   w_rdRing;
    logic [LP_AW-1:0]      w_wrAddr, w_rdAddr;
    logic [g_WIDTH-1:0]    w_rdData;

    assign w_inReady   = (r_state != EMIT);
    assign w_inFire    = bus.i_axisInValid && w_inReady;
    assign w_chWrap    = (r_chIdx == LP_CH_W'(g_CHANNELS - 1));
    assign w_setDone   = w_inFire && w_chWrap;

    assign w_pop       = r_outValid && bus.i_axisOutReady;
    assign w_lastBeat  = w_pop && r_outLast && (r_outCh == LP_CH_W'(g_CHANNELS - 1));
    // A new read may launch whenever the RAM output register is free or draining.
    assign w_issue     = (r_state == EMIT) && !r_rdDone && (!r_outValid || bus.i_axisOutReady);
    assign w_rdIdxLast = (r_rdIdx == LP_IDX_W'(g_N - 1));
    assign w_rdChLast  = (r_rdCh == LP_CH_W'(g_CHANNELS - 1));

    // wrIdx is frozen during EMIT and points at the oldest slot of every channel.
    assign w_rdRing = r_wrIdx + r_rdIdx;
    assign w_wrAddr = LP_AW'({r_chIdx, r_wrIdx});
    assign w_rdAddr = LP_AW'({r_rdCh, w_rdRing});

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= FILL;
        else         r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            FILL: if (w_setDone && r_setCnt == LP_CNT_W'(g_N - 1))   w_nextState = EMIT;
            HOP:  if (w_setDone && r_setCnt == LP_CNT_W'(g_HOP - 1)) w_nextState = EMIT;
            EMIT: if (w_lastBeat)                                   w_nextState = HOP;
            default:                                                w_nextState = FILL;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_chIdx  <= '0;
            r_wrIdx  <= '0;
            r_setCnt <= '0;
        end else begin
            if (w_inFire) begin
                r_chIdx <= w_chWrap ? '0 : r_chIdx + 1'b1;
                if (w_chWrap) r_wrIdx <= r_wrIdx + 1'b1;
            end
            if (r_state == EMIT) r_setCnt <= '0;
            else if (w_setDone)  r_setCnt <= r_setCnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rdCh     <= '0;
            r_rdIdx    <= '0;
            r_rdDone   <= 1'b0;
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
            r_outCh    <= '0;
        end else begin
            if (r_state != EMIT) begin
                r_rdCh   <= '0;
                r_rdIdx  <= '0;
                r_rdDone <= 1'b0;
            end else if (w_issue) begin
                r_rdIdx <= r_rdIdx + 1'b1;
                if (w_rdIdxLast) begin
                    if (w_rdChLast) r_rdDone <= 1'b1;
                    else            r_rdCh   <= r_rdCh + 1'b1;
                end
            end
            if (w_issue) begin
                r_outValid <= 1'b1;
                r_outLast  <= w_rdIdxLast;
                r_outCh    <= r_rdCh;
            end else if (w_pop) begin
                r_outValid <= 1'b0;
            end
        end
    end

    framer_ram #(
        .g_DEPTH  (g_CHANNELS * g_N),
        .g_WIDTH  (g_WIDTH),
        .g_ADDR_W (LP_AW)
    ) u_ram (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_wrEn   (w_inFire),
        .i_wrAddr (w_wrAddr),
        .i_wrData (bus.i_axisInData),
        .i_rdEn   (w_issue),
        .i_rdAddr (w_rdAddr),
        .o_rdData (w_rdData)
    );

    assign bus.o_axisInReady    = w_inReady;
    assign bus.o_axisOutData    = w_rdData;
    assign bus.o_axisOutValid   = r_outValid;
    assign bus.o_axisOutLast    = r_outLast;
    assign bus.o_axisOutChannel = r_outCh;
endmodule
